uart_byte_tx: RTL and testbench

//   Serializes bytes from a ready/valid byte stream (e.g. ALU result path) onto
//   an 8-N-1-style UART TX line. This is the transmit end of the UART link that

---
 rtl/uart_byte_tx.sv | 153 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: ready/valid byte stream in, 8-N-1 style TX line out.
// Ports: clk_i, rst_ni (async low), data_i/valid_i/ready_o, tx_o, busy_o.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $fatal(1, "uart_byte_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_pe
        $fatal(1, "uart_byte_tx: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_po
        $fatal(1, "uart_byte_tx: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
        $fatal(1, "uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] baud_q, baud_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic          par_q, par_n;
    logic [7:0]    hold_data_q;
    logic          hold_valid_q;
    logic          tx_q, tx_n;
    logic          wrap;
    logic          take;
    logic          hs;

    assign ready_o = !hold_valid_q;
    assign hs      = valid_i && !hold_valid_q;
    assign tx_o    = tx_q;
    assign busy_o  = (state_q != S_IDLE) || hold_valid_q;

    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        par_n   = par_q;
        take    = 1'b0;
        tx_n    = 1'b1;
        wrap    = (baud_q == BAUD_MAX);
        if (state_q != S_IDLE) begin
            baud_n = wrap ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: take = hold_valid_q;
            S_START: begin
                if (wrap) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shift_n = {1'b0, shift_q[7:1]};
                    bit_n   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        bit_n   = '0;
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (bit_q == STOP_LAST) begin
                        state_n = S_IDLE;
                        // held byte starts right away: no idle gap
                        take    = hold_valid_q;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (take) begin
            state_n = S_START;
            baud_n  = '0;
            bit_n   = '0;
            shift_n = hold_data_q;
            par_n   = (^hold_data_q) ^ PAR_ODD;
        end
        // line level follows the next state so tx_o is a clean flop
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            // hs needs an empty slot, take needs a full one: exclusive
            if (hs) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= data_i;
            end else if (take) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx: four parameter variants, waveform table checks,
// back-to-back, reset mid-frame and a UART RX scoreboard on variant 0.
module tb_uart_byte_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid [4];
    logic       ready [4];
    logic       tx    [4];
    logic       busy  [4];

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));
    uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid[3]),
        .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]));

    // RX model on dut0 (8-N-1), samples mid-bit
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_busy = 1'b0;
            rx_cnt  = 0;
        end else if (!rx_busy) begin
            if (tx[0] == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                    rx_byte[rx_cnt / CPB - 1] = tx[0];
                end else if (rx_cnt / CPB == 9) begin
                    rx_busy = 1'b0;
                    checks++;
                    if (tx[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL rx_framing: stop=%b required 1", tx[0]);
                    end else if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected: got %0d, none queued", rx_byte);
                    end else begin
                        rx_exp = sb.pop_front();
                        if (rx_byte !== rx_exp) begin
                            errors++;
                            $display("FAIL rx_byte: got %0d required %0d", rx_byte, rx_exp);
                        end
                    end
                end
            end
        end
    end

    // caller sits at a negedge; returns at the negedge after the handshake
    task automatic send(input int i, input logic [7:0] d);
        int n;
        n = 0;
        data = d;
        valid[i] = 1'b1;
        while (!ready[i] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: inst %0d byte %0d not accepted", i, d);
            valid[i] = 1'b0;
        end else begin
            @(posedge clk);
            if (i == 0) sb.push_back(d);
            @(negedge clk);
            valid[i] = 1'b0;
        end
    endtask

    task automatic check_frame(input int i, input logic [7:0] d, input bit pe,
                               input bit par, input int stops,
                               input bit idle_end, input string tag);
        int len;
        int b;
        int bad_c;
        logic exp_b;
        logic got_b;
        logic bad_exp;
        len = (9 + int'(pe) + stops) * CPB;
        bad_c = -1;
        got_b = 1'b0;
        bad_exp = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            b = c / CPB;
            if (b == 0) exp_b = 1'b0;
            else if (b <= 8) exp_b = d[b-1];
            else if (pe && b == 9) exp_b = par;
            else exp_b = 1'b1;
            if (c == 0) begin
                checks++;
                if (ready[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_start: got %b required 1", tag, ready[i]);
                end
            end
            if (tx[i] !== exp_b && bad_c < 0) begin
                bad_c = c;
                got_b = tx[i];
                bad_exp = exp_b;
            end
            if (c == len - 1) begin
                checks++;
                if (busy[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy_last: got %b required 1", tag, busy[i]);
                end
            end
        end
        checks++;
        if (bad_c >= 0) begin
            errors++;
            $display("FAIL %s_wave: cycle %0d tx=%b required %b", tag, bad_c, got_b, bad_exp);
        end
        if (idle_end) begin
            @(negedge clk);
            checks++;
            if (busy[i] !== 1'b0 || tx[i] !== 1'b1) begin
                errors++;
                $display("FAIL %s_end: busy=%b tx=%b required 0 1", tag, busy[i], tx[i]);
            end
        end
    endtask

    typedef struct {
        int         inst;
        logic [7:0] d;
        bit         pe;
        bit         par;
        int         stops;
        string      tag;
    } vec_t;

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = '{0, 8'h02, 1'b0, 1'b0, 1, "send2"};
        vecs[1] = '{1, 8'hAA, 1'b1, 1'b0, 1, "even_aa"};
        vecs[2] = '{1, 8'h07, 1'b1, 1'b1, 1, "even_07"};
        vecs[3] = '{2, 8'hAA, 1'b1, 1'b1, 1, "odd_aa"};
        vecs[4] = '{3, 8'hFF, 1'b0, 1'b0, 2, "stop2_ff"};
        vecs[5] = '{0, 8'hC3, 1'b0, 1'b0, 1, "send_c3"};
        for (int i = 0; i < 4; i++) valid[i] = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_%0d: tx=%b ready=%b busy=%b required 1 1 0",
                         i, tx[i], ready[i], busy[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].inst, vecs[v].d);
            check_frame(vecs[v].inst, vecs[v].d, vecs[v].pe, vecs[v].par,
                        vecs[v].stops, 1'b1, vecs[v].tag);
            @(negedge clk);
        end

        send(0, 8'd9);
        fork
            check_frame(0, 8'd9, 1'b0, 1'b0, 1, 1'b0, "b2b_9");
            begin
                repeat (10) @(negedge clk);
                send(0, 8'd170);
                checks++;
                if (ready[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_held: got %b required 0", ready[0]);
                end
            end
        join
        check_frame(0, 8'd170, 1'b0, 1'b0, 1, 1'b1, "b2b_170");
        @(negedge clk);

        send(0, 8'h55);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b ready=%b busy=%b required 1 1 0",
                     tx[0], ready[0], busy[0]);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'h55);
        check_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, "after_reset");
        @(negedge clk);

        send(0, 8'd170);
        send(0, 8'd9);
        send(0, 8'd2);
        n = 0;
        while ((sb.size() != 0 || rx_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL stream_timeout: %0d bytes undelivered", sb.size());
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_end: busy=%b left=%0d required 0 0", busy[0], sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
